// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and the cipher core that
// consumes its blocks.
//   packer_state_t        : block packer FSM states
//   UART_BYTES_PER_BLOCK  : default block size in bytes (one 128-bit AES block)
//   block_width()         : bytes -> block width in bits
//   counter_width()       : bits needed to hold 0..max_value (at least 1)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } packer_state_t;

    localparam int unsigned UART_BYTES_PER_BLOCK = 32'd16;

    function automatic int unsigned block_width(input int unsigned bytes);
        return 32'd8 * bytes;
    endfunction

    function automatic int unsigned counter_width(input int unsigned max_value);
        int unsigned w;
        w = $clog2(max_value + 32'd1);
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// -----------------------------------------------------------------------------
// uart_idle_timer
// Counts idle clocks while run_i is high and flags the terminal count.
//   clock_fpga : system clock
//   reset      : synchronous, active-high
//   run_i      : count this cycle
//   clear_i    : force the count back to zero (dominates run_i)
//   expire_o   : high for the single cycle in which the count sits at
//                TIMEOUT_CYCLES-1 while running, i.e. the TIMEOUT_CYCLES-th
//                consecutive idle cycle
// -----------------------------------------------------------------------------
module uart_idle_timer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic clock_fpga,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = counter_width(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_terminal_s;

    assign at_terminal_s = (count_q == TERMINAL);
    // Expiry is combinational so the packer can act on the same edge.
    assign expire_o      = run_i && !clear_i && at_terminal_s;

    // Next-state of the idle counter; wraps to zero on expiry.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (run_i) begin
            if (at_terminal_s) begin
                count_d = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_block_packer.sv
// -----------------------------------------------------------------------------
// uart_block_packer
// Collects received UART bytes into a BYTES_PER_BLOCK-byte block and hands it
// to the cipher core over a valid/ready handshake. A complete block is held
// until accepted; bytes arriving while the block is stalled are dropped and
// flagged with a sticky overrun.
//
// Optional feature: define RX_TIMEOUT_EN to discard a partial block after
// TIMEOUT_CYCLES idle clocks (timeout pulses). Without it timeout is 0 and a
// partial block waits indefinitely.
//
// Ports
//   clock_fpga  in   system clock
//   reset       in   synchronous, active-high
//   rx_data     in   received byte, qualified by rx_valid
//   rx_valid    in   one-cycle strobe per received byte
//   block_data  out  assembled block, first byte in the top 8 bits
//   block_valid out  block complete and stable
//   block_ready in   consumer accepts the block
//   byte_count  out  bytes in the current block (saturates while FULL)
//   overrun     out  sticky: a byte was dropped
//   timeout     out  one-cycle pulse: a partial block was discarded
// -----------------------------------------------------------------------------
module uart_block_packer
    import uart_pkg::*;
#(
    parameter int unsigned BYTES_PER_BLOCK = UART_BYTES_PER_BLOCK,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd1_000_000,
    parameter int unsigned BLOCK_W         = block_width(BYTES_PER_BLOCK),
    parameter int unsigned COUNT_W         = $clog2(BYTES_PER_BLOCK + 32'd1)
) (
    input  logic               clock_fpga,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [BLOCK_W-1:0] block_data,
    output logic               block_valid,
    input  logic               block_ready,
    output logic [COUNT_W-1:0] byte_count,
    output logic               overrun,
    output logic               timeout
);

    if ((BYTES_PER_BLOCK < 32'd2) || (BYTES_PER_BLOCK > 32'd32) ||
        (TIMEOUT_CYCLES < 32'd1)) begin : g_bad_param
        $error("uart_block_packer: parameter out of range");
    end

    // Count value held just before the final byte of a block arrives.
    localparam logic [COUNT_W-1:0] LAST_BEFORE_FULL = COUNT_W'(BYTES_PER_BLOCK - 32'd1);

    packer_state_t      state_q,   state_d;
    logic [BLOCK_W-1:0] data_q,    data_d;
    logic               valid_q,   valid_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic               expire_s;

`ifdef RX_TIMEOUT_EN
    logic partial_s;
    logic timer_run_s;
    logic timer_clear_s;

    assign partial_s     = (state_q == COLLECT) && (count_q != {COUNT_W{1'b0}});
    assign timer_run_s   = partial_s && !rx_valid;
    assign timer_clear_s = rx_valid || !partial_s;

    uart_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clock_fpga (clock_fpga),
        .reset      (reset),
        .run_i      (timer_run_s),
        .clear_i    (timer_clear_s),
        .expire_o   (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next-state and output-register logic of the packer FSM.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (rx_valid) begin
                    data_d  = {data_q[BLOCK_W-9:0], rx_data};
                    count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    if (count_q == LAST_BEFORE_FULL) begin
                        state_d = FULL;
                        valid_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end else if (expire_s) begin
                    data_d    = {BLOCK_W{1'b0}};
                    count_d   = {COUNT_W{1'b0}};
                    timeout_d = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            FULL: begin
                if (block_ready) begin
                    state_d = COLLECT;
                    valid_d = 1'b0;
                    // A byte arriving with the handshake opens the next block.
                    if (rx_valid) begin
                        data_d  = {{(BLOCK_W-8){1'b0}}, rx_data};
                        count_d = {{(COUNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        count_d = {COUNT_W{1'b0}};
                    end
                end else if (rx_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = COLLECT;
                data_d  = {BLOCK_W{1'b0}};
                valid_d = 1'b0;
                count_d = {COUNT_W{1'b0}};
            end
        endcase
    end

    // Packer state and output registers.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            state_q   <= COLLECT;
            data_q    <= {BLOCK_W{1'b0}};
            valid_q   <= 1'b0;
            count_q   <= {COUNT_W{1'b0}};
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign block_data  = data_q;
    assign block_valid = valid_q;
    assign byte_count  = count_q;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_uart_block_packer.sv
module tb_uart_block_packer;

    logic         clock_fpga = 1'b0;
    logic         reset      = 1'b1;
    logic [7:0]   rx_data    = 8'h00;
    logic         rx_valid   = 1'b0;
    logic         block_ready = 1'b0;
    logic [127:0] block_data;
    logic         block_valid;
    logic [4:0]   byte_count;
    logic         overrun;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    always #5 clock_fpga = ~clock_fpga;

    uart_block_packer #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock_fpga  (clock_fpga),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .block_data  (block_data),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .byte_count  (byte_count),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    typedef struct {
        bit           rst;
        bit           v;
        logic [7:0]   d;
        bit           rdy;
        bit           e_valid;
        logic [4:0]   e_count;
        bit           e_ovr;
        bit           chk_data;
        logic [127:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_fpga);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit rdy);
        reset       = 1'b0;
        rx_valid    = v;
        rx_data     = d;
        block_ready = rdy;
        tick();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        block_ready = 1'b0;
        tick();
        reset       = 1'b0;
    endtask

    function automatic void add(input bit rst, input bit v, input logic [7:0] d, input bit rdy,
                                input bit e_valid, input logic [4:0] e_count, input bit e_ovr,
                                input bit chk_data, input logic [127:0] e_data);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.rdy = rdy;
        t.e_valid = e_valid; t.e_count = e_count; t.e_ovr = e_ovr;
        t.chk_data = chk_data; t.e_data = e_data;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [127:0] blk_00_0f;
        logic [127:0] blk_a0_af;
        bit           seen;
        blk_00_0f = 128'h000102030405060708090a0b0c0d0e0f;
        blk_a0_af = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

        // Table: reset, a block with ready held high, then a stalled block with overrun.
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 128'h0);
        for (int k = 0; k < 16; k++)
            add(1'b0, 1'b1, 8'(k), 1'b1, (k == 15), (k == 15) ? 5'd16 : 5'(k + 1), 1'b0,
                (k == 15), blk_00_0f);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 128'h0);
        for (int k = 0; k < 16; k++)
            add(1'b0, 1'b1, 8'(8'ha0 + k), 1'b0, (k == 15), 5'(k + 1), 1'b0, (k == 15), blk_a0_af);
        add(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 5'd16, 1'b1, 1'b1, blk_a0_af);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b1, blk_a0_af);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 128'h0);
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 128'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            rx_valid    = vecs[i].v;
            rx_data     = vecs[i].d;
            block_ready = vecs[i].rdy;
            tick();
            check_val($sformatf("vec%0d valid", i), 128'(block_valid), 128'(vecs[i].e_valid));
            check_val($sformatf("vec%0d count", i), 128'(byte_count), 128'(vecs[i].e_count));
            check_val($sformatf("vec%0d overrun", i), 128'(overrun), 128'(vecs[i].e_ovr));
            check_val($sformatf("vec%0d timeout", i), 128'(timeout), 128'h0);
            if (vecs[i].chk_data)
                check_val($sformatf("vec%0d data", i), block_data, vecs[i].e_data);
        end

        // Byte arriving together with the handshake starts the next block.
        do_reset();
        for (int k = 0; k < 16; k++) drive(1'b1, 8'(8'hb0 + k), 1'b0);
        check_val("hs_full_valid", 128'(block_valid), 128'h1);
        drive(1'b1, 8'h77, 1'b1);
        check_val("hs_valid", 128'(block_valid), 128'h0);
        check_val("hs_count", 128'(byte_count), 128'h1);
        check_val("hs_overrun", 128'(overrun), 128'h0);
        check_val("hs_data", block_data, 128'h77);
        for (int k = 1; k < 16; k++) drive(1'b1, 8'(k), 1'b1);
        check_val("hs_next_valid", 128'(block_valid), 128'h1);
        check_val("hs_next_count", 128'(byte_count), 128'd16);
        check_val("hs_next_data", block_data, 128'h770102030405060708090a0b0c0d0e0f);
        drive(1'b0, 8'h00, 1'b1);
        check_val("hs_after_count", 128'(byte_count), 128'h0);

        // Reset mid-block with overrun set clears everything.
        for (int k = 0; k < 17; k++) drive(1'b1, 8'(8'hc0 + k), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_val("pre_rst_overrun", 128'(overrun), 128'h1);
        for (int k = 1; k <= 5; k++) drive(1'b1, 8'(k), 1'b1);
        check_val("pre_rst_count", 128'(byte_count), 128'd5);
        do_reset();
        check_val("rst_data", block_data, 128'h0);
        check_val("rst_valid", 128'(block_valid), 128'h0);
        check_val("rst_count", 128'(byte_count), 128'h0);
        check_val("rst_overrun", 128'(overrun), 128'h0);
        check_val("rst_timeout", 128'(timeout), 128'h0);
        for (int k = 0; k < 16; k++) drive(1'b1, 8'(8'h10 + k), 1'b0);
        check_val("post_rst_valid", 128'(block_valid), 128'h1);
        check_val("post_rst_data", block_data, 128'h101112131415161718191a1b1c1d1e1f);
        drive(1'b0, 8'h00, 1'b1);
        check_val("post_rst_accept", 128'(block_valid), 128'h0);

`ifdef RX_TIMEOUT_EN
        // Partial block discarded after 100 idle cycles.
        do_reset();
        for (int k = 1; k <= 3; k++) drive(1'b1, 8'(k), 1'b1);
        seen = 1'b0;
        for (int j = 1; j < 100; j++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (timeout) seen = 1'b1;
        end
        check_val("to_early", 128'(seen), 128'h0);
        check_val("to_early_count", 128'(byte_count), 128'd3);
        drive(1'b0, 8'h00, 1'b1);
        check_val("to_pulse", 128'(timeout), 128'h1);
        check_val("to_count", 128'(byte_count), 128'h0);
        check_val("to_data", block_data, 128'h0);
        drive(1'b0, 8'h00, 1'b1);
        check_val("to_one_cycle", 128'(timeout), 128'h0);

        // A byte on the terminal idle cycle wins over the timeout.
        do_reset();
        for (int k = 1; k <= 3; k++) drive(1'b1, 8'(k), 1'b1);
        for (int j = 1; j < 100; j++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h44, 1'b1);
        check_val("to_race_timeout", 128'(timeout), 128'h0);
        check_val("to_race_count", 128'(byte_count), 128'd4);
        drive(1'b0, 8'h00, 1'b1);
        check_val("to_race_after", 128'(timeout), 128'h0);
`else
        // Without the timeout feature a partial block waits indefinitely.
        do_reset();
        for (int k = 1; k <= 3; k++) drive(1'b1, 8'(k), 1'b1);
        seen = 1'b0;
        for (int j = 0; j < 10000; j++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (timeout) seen = 1'b1;
        end
        check_val("idle_timeout", 128'(seen), 128'h0);
        check_val("idle_count", 128'(byte_count), 128'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
